// File: rtl/pec_ctrl_seq.sv
// pec_ctrl_seq: sequencer for the PEC in-memory-compute segment.
// Runs four commands (clear, weight programming, bias load, compute). It
// handshakes with the source and sink streamers and drives the word-line,
// bit-line, write-column and bit-serial input selects.
module pec_ctrl_seq #(
  parameter int N_FILT   = 16,
  parameter int N_PIX    = 9,
  parameter int IN_BITS  = 4,
  parameter int BL_GROUP = 4,
  parameter int SEG_ROW  = 16,
  parameter int SEG_COL  = 8,
  parameter int N_WCOL   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [1:0]                        op_i,
  input  logic [$clog2(SEG_ROW)-1:0]        wl_idx_i,
  input  logic [$clog2(SEG_COL)-1:0]        bl_base_i,
  input  logic [$clog2(N_WCOL)-1:0]         wcol_base_i,
  input  logic [$clog2(IN_BITS):0]          in_bits_i,
  input  logic [N_FILT*N_PIX*IN_BITS-1:0]   in_bit_buff_i,
  output logic                              src_req_o,
  input  logic                              src_valid_i,
  input  logic                              src_more_i,
  output logic                              snk_valid_o,
  input  logic                              snk_ready_i,
  output logic [3:0]                        state_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic                              trigger_acc_o,
  output logic                              clear_acc_o,
  output logic [N_FILT*N_PIX-1:0]           in_bit_o,
  output logic [SEG_ROW-1:0]                wl_o,
  output logic [SEG_COL-1:0]                bl_o,
  output logic [N_FILT*N_WCOL-1:0]          write_col_sels_o,
  output logic [$clog2(N_WCOL):0]           ft_cnt_o
);

  localparam int WL_W  = $clog2(SEG_ROW);
  localparam int BLB_W = $clog2(SEG_COL);
  localparam int WC_W  = $clog2(N_WCOL);
  localparam int INB_W = $clog2(IN_BITS) + 1;
  localparam int FT_W  = $clog2(N_WCOL) + 1;
  localparam int BLC_W = (BL_GROUP > 1) ? $clog2(BL_GROUP) : 1;
  localparam int BIT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_FETCH_W  = 4'd2,
    S_PROG     = 4'd3,
    S_FETCH_B  = 4'd4,
    S_FETCH_IN = 4'd5,
    S_COMPUTE  = 4'd6,
    S_STORE    = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR      = 2'd0,
    OP_LD_WEIGHTS = 2'd1,
    OP_LD_BIAS    = 2'd2,
    OP_COMPUTE    = 2'd3
  } op_t;

  state_t           state_q;
  logic [BLC_W-1:0] bl_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [FT_W-1:0]  ft_cnt_q;
  logic             more_q;
  logic             err_q;
  logic             done_q;
  logic             clr_cmd_q;   // CLEAR was entered by a command, not by reset
  logic [WL_W-1:0]  wl_idx_q;
  logic [BLB_W-1:0] bl_base_q;
  logic [WC_W-1:0]  wcol_base_q;
  logic [INB_W-1:0] in_bits_q;

  logic             cfg_err;
  logic             wcol_ovf;
  logic             bl_last;
  logic             bit_last;
  logic [BLB_W-1:0] bl_idx;
  logic [WC_W-1:0]  wcol_idx;

  // Command range check on the raw inputs, evaluated when start_i is honoured.
  assign cfg_err = (in_bits_i == '0) || (int'(in_bits_i) > IN_BITS) ||
                   (int'(bl_base_i) + BL_GROUP > SEG_COL) ||
                   (int'(wl_idx_i) >= SEG_ROW);

  // The next chunk would land past the last write column.
  assign wcol_ovf = (int'(wcol_base_q) + int'(ft_cnt_q)) >= N_WCOL;

  assign bl_last  = (bl_cnt_q == BLC_W'(BL_GROUP - 1));
  assign bit_last = (int'(bit_cnt_q) == int'(in_bits_q) - 1);
  assign bl_idx   = bl_base_q + BLB_W'(bl_cnt_q);
  assign wcol_idx = wcol_base_q + ft_cnt_q[WC_W-1:0];

  // Main sequencer: state, counters, shadow config and status flags.
  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_CLEAR;
      bl_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      ft_cnt_q    <= '0;
      more_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      clr_cmd_q   <= 1'b0;
      wl_idx_q    <= '0;
      bl_base_q   <= '0;
      wcol_base_q <= '0;
      in_bits_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            wl_idx_q    <= wl_idx_i;
            bl_base_q   <= bl_base_i;
            wcol_base_q <= wcol_base_i;
            in_bits_q   <= in_bits_i;
            ft_cnt_q    <= '0;
            more_q      <= 1'b0;
            clr_cmd_q   <= (op_t'(op_i) == OP_CLEAR);
            if (cfg_err) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
              unique case (op_t'(op_i))
                OP_CLEAR:      state_q <= S_CLEAR;
                OP_LD_WEIGHTS: state_q <= S_FETCH_W;
                OP_LD_BIAS:    state_q <= S_FETCH_B;
                OP_COMPUTE:    state_q <= S_FETCH_IN;
                default:       state_q <= S_IDLE;
              endcase
            end
          end
        end
        S_CLEAR: begin
          state_q   <= S_IDLE;
          done_q    <= clr_cmd_q;
          clr_cmd_q <= 1'b0;
        end
        S_FETCH_W: begin
          if (src_valid_i) begin
            more_q <= src_more_i;
            if (wcol_ovf) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_PROG;
            end
          end
        end
        S_FETCH_B: begin
          if (src_valid_i) begin
            more_q  <= src_more_i;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_FETCH_IN: begin
          if (src_valid_i) begin
            more_q  <= src_more_i;
            state_q <= S_COMPUTE;
          end
        end
        S_PROG: begin
          if (bl_last) begin
            bl_cnt_q  <= '0;
            bit_cnt_q <= '0;
            ft_cnt_q  <= ft_cnt_q + 1'b1;
            done_q    <= !more_q;
            state_q   <= more_q ? S_FETCH_W : S_IDLE;
          end else begin
            bl_cnt_q  <= bl_cnt_q + 1'b1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (bl_last) begin
            bl_cnt_q <= '0;
            if (bit_last) begin
              bit_cnt_q <= '0;
              state_q   <= S_STORE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            bl_cnt_q <= bl_cnt_q + 1'b1;
          end
        end
        S_STORE: begin
          if (snk_ready_i) begin
            done_q  <= !more_q;
            state_q <= more_q ? S_FETCH_IN : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded straight from the state register.
  assign state_o       = state_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ft_cnt_o      = ft_cnt_q;
  assign src_req_o     = (state_q == S_FETCH_W) || (state_q == S_FETCH_B) ||
                         (state_q == S_FETCH_IN);
  assign snk_valid_o   = (state_q == S_STORE);
  assign trigger_acc_o = (state_q == S_COMPUTE);
  assign clear_acc_o   = (state_q == S_CLEAR);

  // Array selects: lines are driven only while the array is being accessed.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wl_o             = '0;
    bl_o             = '0;
    write_col_sels_o = '0;
    if (state_q == S_PROG || state_q == S_COMPUTE) begin
      wl_o = SEG_ROW'(1) << wl_idx_q;
      bl_o = SEG_COL'(1) << bl_idx;
    end
    if (state_q == S_PROG) begin
      write_col_sels_o = {N_FILT{N_WCOL'(1) << wcol_idx}};
    end
  end

  // Bit-serial input slice: bit bit_cnt of every [filter][pixel] entry.
  for (genvar i = 0; i < N_FILT * N_PIX; i++) begin : g_in_bit
    logic [IN_BITS-1:0] bits;
    assign bits        = in_bit_buff_i[i*IN_BITS +: IN_BITS];
    assign in_bit_o[i] = bits[bit_cnt_q];
  end

endmodule

// File: tb/tb_pec_ctrl_seq.sv
// tb_pec_ctrl_seq: directed bench for pec_ctrl_seq with a vector table for
// single-cycle behaviour and hand-written multi-cycle sequences.
module tb_pec_ctrl_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [3:0]   wl_idx;
  logic [2:0]   bl_base;
  logic [3:0]   wcol_base;
  logic [2:0]   in_bits;
  logic [575:0] in_bit_buff;
  logic         src_req, src_valid, src_more;
  logic         snk_valid, snk_ready;
  logic [3:0]   state;
  logic         busy, done, err, trigger_acc, clear_acc;
  logic [143:0] in_bit;
  logic [15:0]  wl;
  logic [7:0]   bl;
  logic [255:0] write_col_sels;
  logic [4:0]   ft_cnt;

  int checks = 0;
  int errors = 0;

  pec_ctrl_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .wl_idx_i(wl_idx), .bl_base_i(bl_base), .wcol_base_i(wcol_base),
    .in_bits_i(in_bits), .in_bit_buff_i(in_bit_buff),
    .src_req_o(src_req), .src_valid_i(src_valid), .src_more_i(src_more),
    .snk_valid_o(snk_valid), .snk_ready_i(snk_ready),
    .state_o(state), .busy_o(busy), .done_o(done), .err_o(err),
    .trigger_acc_o(trigger_acc), .clear_acc_o(clear_acc),
    .in_bit_o(in_bit), .wl_o(wl), .bl_o(bl),
    .write_col_sels_o(write_col_sels), .ft_cnt_o(ft_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [1:0]  op;
    logic [3:0]  wl_idx;
    logic [2:0]  bl_base;
    logic [3:0]  wcol_base;
    logic [2:0]  in_bits;
    logic        src_valid;
    logic        src_more;
    logic        snk_ready;
    logic [3:0]  e_state;
    logic        e_done;
    logic        e_err;
    logic        e_req;
    logic        e_clr;
    logic [15:0] e_wl;
    logic [7:0]  e_bl;
    logic [15:0] e_wsel;
    logic [4:0]  e_ft;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    logic st, logic [1:0] o, logic [3:0] wi, logic [2:0] bb, logic [3:0] wc, logic [2:0] ib,
    logic sv, logic sm, logic sr,
    logic [3:0] es, logic ed, logic ee, logic erq, logic ec,
    logic [15:0] ew, logic [7:0] eb, logic [15:0] ews, logic [4:0] ef);
    vec_t v;
    v.start = st; v.op = o; v.wl_idx = wi; v.bl_base = bb; v.wcol_base = wc; v.in_bits = ib;
    v.src_valid = sv; v.src_more = sm; v.snk_ready = sr;
    v.e_state = es; v.e_done = ed; v.e_err = ee; v.e_req = erq; v.e_clr = ec;
    v.e_wl = ew; v.e_bl = eb; v.e_wsel = ews; v.e_ft = ef;
    return v;
  endfunction

  // Expected bit-serial slice: bit b of every [filter][pixel] entry.
  function automatic logic [143:0] exp_slice(int b);
    logic [143:0] r;
    for (int i = 0; i < 144; i++) r[i] = in_bit_buff[i*4 + b];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; wl_idx = 4'd0; bl_base = 3'd0;
    wcol_base = 4'd0; in_bits = 3'd1; src_valid = 1'b0; src_more = 1'b0; snk_ready = 1'b0;
    for (int i = 0; i < 18; i++) in_bit_buff[i*32 +: 32] = $urandom;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst state", 256'(state), 256'(4'd1));
    check("rst clear_acc", 256'(clear_acc), 256'(1'b1));
    check("rst busy", 256'(busy), 256'(1'b1));
    check("rst done", 256'(done), 256'(1'b0));
    check("rst err", 256'(err), 256'(1'b0));
    check("rst selects", {src_req, snk_valid, trigger_acc, wl, bl, ft_cnt}, '0);
    check("rst wsel", write_col_sels, '0);
    rst_n = 1'b1;
    tick();
    check("post-rst state", 256'(state), 256'(4'd0));
    check("post-rst busy", 256'(busy), 256'(1'b0));
    check("post-rst clear_acc", 256'(clear_acc), 256'(1'b0));
    check("post-rst done", 256'(done), 256'(1'b0));

    // Vector table: st op wl bb wc ib | sv sm sr | state done err req clr | wl bl wsel ft
    vecs.push_back(mk(0,0,5,4,2,1, 0,0,0, 0,0,0,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(1,1,5,4,2,1, 0,0,0, 2,0,0,1,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 2,0,0,1,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,1,5,4,2,1, 1,1,0, 3,0,0,0,0, 16'h0020,8'h10,16'h0004,0));
    vecs.push_back(mk(1,3,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h20,16'h0004,0));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h40,16'h0004,0));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h80,16'h0004,0));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 2,0,0,1,0, 16'h0000,8'h00,16'h0000,1));
    vecs.push_back(mk(0,1,5,4,2,1, 1,0,0, 3,0,0,0,0, 16'h0020,8'h10,16'h0008,1));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h20,16'h0008,1));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h40,16'h0008,1));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 3,0,0,0,0, 16'h0020,8'h80,16'h0008,1));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 0,1,0,0,0, 16'h0000,8'h00,16'h0000,2));
    vecs.push_back(mk(0,1,5,4,2,1, 0,0,0, 0,0,0,0,0, 16'h0000,8'h00,16'h0000,2));
    vecs.push_back(mk(1,3,5,4,2,0, 0,0,0, 0,1,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,3,5,4,2,0, 0,0,0, 0,0,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(1,2,5,5,2,4, 0,0,0, 0,1,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,2,5,5,2,4, 0,0,0, 0,0,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(1,3,5,4,2,5, 0,0,0, 0,1,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,3,5,4,2,5, 0,0,0, 0,0,1,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(1,0,5,4,2,4, 0,0,0, 1,0,0,0,1, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,0,5,4,2,4, 0,0,0, 0,1,0,0,0, 16'h0000,8'h00,16'h0000,0));
    vecs.push_back(mk(0,0,5,4,2,4, 0,0,0, 0,0,0,0,0, 16'h0000,8'h00,16'h0000,0));

    foreach (vecs[i]) begin
      start = vecs[i].start; op = vecs[i].op; wl_idx = vecs[i].wl_idx;
      bl_base = vecs[i].bl_base; wcol_base = vecs[i].wcol_base; in_bits = vecs[i].in_bits;
      src_valid = vecs[i].src_valid; src_more = vecs[i].src_more; snk_ready = vecs[i].snk_ready;
      tick();
      check($sformatf("v%0d state", i), 256'(state), 256'(vecs[i].e_state));
      check($sformatf("v%0d done", i), 256'(done), 256'(vecs[i].e_done));
      check($sformatf("v%0d err", i), 256'(err), 256'(vecs[i].e_err));
      check($sformatf("v%0d src_req", i), 256'(src_req), 256'(vecs[i].e_req));
      check($sformatf("v%0d clear_acc", i), 256'(clear_acc), 256'(vecs[i].e_clr));
      check($sformatf("v%0d wl", i), 256'(wl), 256'(vecs[i].e_wl));
      check($sformatf("v%0d bl", i), 256'(bl), 256'(vecs[i].e_bl));
      check($sformatf("v%0d wsel", i), write_col_sels, {16{vecs[i].e_wsel}});
      check($sformatf("v%0d ft_cnt", i), 256'(ft_cnt), 256'(vecs[i].e_ft));
    end
    start = 1'b0;

    // COMPUTE, in_bits=3: 12 trigger cycles, then STORE held 5 cycles
    start = 1'b1; op = 2'd3; wl_idx = 4'd2; bl_base = 3'd1; in_bits = 3'd3;
    tick();
    start = 1'b0;
    check("cmp fetch state", 256'(state), 256'(4'd5));
    check("cmp fetch req", 256'(src_req), 256'(1'b1));
    src_valid = 1'b1; src_more = 1'b0;
    tick();
    src_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("cmp%0d state", i), 256'(state), 256'(4'd6));
      check($sformatf("cmp%0d trigger", i), 256'(trigger_acc), 256'(1'b1));
      check($sformatf("cmp%0d bl", i), 256'(bl), 256'(8'(1) << (1 + i % 4)));
      check($sformatf("cmp%0d wl", i), 256'(wl), 256'(16'h0004));
      check($sformatf("cmp%0d in_bit", i), 256'(in_bit), 256'(exp_slice(i / 4)));
      tick();
    end
    check("cmp end trigger", 256'(trigger_acc), 256'(1'b0));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("store%0d state", k), 256'(state), 256'(4'd7));
      check($sformatf("store%0d snk_valid", k), 256'(snk_valid), 256'(1'b1));
      check($sformatf("store%0d done", k), 256'(done), 256'(1'b0));
      if (k == 4) snk_ready = 1'b1;
      tick();
    end
    snk_ready = 1'b0;
    check("cmp done state", 256'(state), 256'(4'd0));
    check("cmp done pulse", 256'(done), 256'(1'b1));
    check("cmp snk_valid low", 256'(snk_valid), 256'(1'b0));
    tick();
    check("cmp done single", 256'(done), 256'(1'b0));

    // LD_BIAS with src_valid delayed 7 cycles: src_req high 8 samples
    start = 1'b1; op = 2'd2; bl_base = 3'd0; in_bits = 3'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bias%0d state", k), 256'(state), 256'(4'd4));
      check($sformatf("bias%0d src_req", k), 256'(src_req), 256'(1'b1));
      if (k == 7) src_valid = 1'b1;
      tick();
    end
    src_valid = 1'b0;
    check("bias end state", 256'(state), 256'(4'd0));
    check("bias done", 256'(done), 256'(1'b1));
    check("bias src_req low", 256'(src_req), 256'(1'b0));
    check("bias err", 256'(err), 256'(1'b0));

    // wcol_base=15: first chunk writes column 15, second PROG entry overflows
    start = 1'b1; op = 2'd1; wl_idx = 4'd0; wcol_base = 4'd15;
    tick();
    start = 1'b0;
    src_valid = 1'b1; src_more = 1'b1;
    tick();
    src_valid = 1'b0;
    check("wc15 prog state", 256'(state), 256'(4'd3));
    check("wc15 wsel", write_col_sels, {16{16'h8000}});
    repeat (4) tick();
    check("wc15 refetch state", 256'(state), 256'(4'd2));
    check("wc15 ft_cnt", 256'(ft_cnt), 256'(5'd1));
    src_valid = 1'b1; src_more = 1'b0;
    tick();
    src_valid = 1'b0;
    check("wc15 abort state", 256'(state), 256'(4'd0));
    check("wc15 err", 256'(err), 256'(1'b1));
    check("wc15 done", 256'(done), 256'(1'b1));
    check("wc15 no write", write_col_sels, '0);
    check("wc15 ft_cnt kept", 256'(ft_cnt), 256'(5'd1));

    // Reset asserted mid-COMPUTE
    start = 1'b1; op = 2'd3; bl_base = 3'd0; in_bits = 3'd4;
    tick();
    start = 1'b0;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    tick();
    check("mid trigger before rst", 256'(trigger_acc), 256'(1'b1));
    #3 rst_n = 1'b0;
    #1;
    check("async rst state", 256'(state), 256'(4'd1));
    check("async rst trigger", 256'(trigger_acc), 256'(1'b0));
    check("async rst clear_acc", 256'(clear_acc), 256'(1'b1));
    tick();
    check("rst edge state", 256'(state), 256'(4'd1));
    check("rst edge done", 256'(done), 256'(1'b0));
    check("rst edge err", 256'(err), 256'(1'b0));
    rst_n = 1'b1;
    tick();
    check("rst exit state", 256'(state), 256'(4'd0));
    check("rst exit done", 256'(done), 256'(1'b0));
    check("rst exit busy", 256'(busy), 256'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pec_ctrl_seq.md
Name: pec_ctrl_seq

Overview:
Parametrised sequencer for the PEC in-memory-compute segment. It drives word-line, bit-line, write-column and bit-serial input selects for four operations: clear, weight programming, bias load and compute. It sits between the register file and source/sink streamers, and talks to them through explicit req/valid/ready handshakes. Relative to the fixed 16x9x4 controller, it adds a runtime input precision, multi-chunk bursts, done/error status and range checking.

Parameters:
N_FILT, 16, filters per segment
N_PIX, 9, pixels per filter
IN_BITS, 4, max input precision (bit-serial steps)
BL_GROUP, 4, bit-lines per weight (bit-line sweep length)
SEG_ROW, 16, word-lines
SEG_COL, 8, bit-lines
N_WCOL, 16, write columns per filter

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
start_i  in  1  single-cycle command strobe, honoured only in IDLE
op_i  in  2  0=CLEAR 1=LD_WEIGHTS 2=LD_BIAS 3=COMPUTE; sampled with start_i
wl_idx_i  in  $clog2(SEG_ROW)  word-line index
bl_base_i  in  $clog2(SEG_COL)  first bit-line
wcol_base_i  in  $clog2(N_WCOL)  first write column
in_bits_i  in  $clog2(IN_BITS)+1  active input precision, legal range 1..IN_BITS
in_bit_buff_i  in  N_FILT*N_PIX*IN_BITS  input buffer, index [f][p][b]
src_req_o  out  1  fetch request
src_valid_i  in  1  fetch chunk complete
src_more_i  in  1  another chunk follows; sampled with src_valid_i
snk_valid_o  out  1  output ready to store
snk_ready_i  in  1  sink accepted output
state_o  out  4  current state encoding
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky config error
trigger_acc_o  out  1  accumulate enable
clear_acc_o  out  1  accumulator clear
in_bit_o  out  N_FILT*N_PIX  current input bit slice
wl_o  out  SEG_ROW  one-hot word-line
bl_o  out  SEG_COL  one-hot bit-line
write_col_sels_o  out  N_FILT*N_WCOL  per-filter one-hot write column
ft_cnt_o  out  $clog2(N_WCOL)+1  chunks programmed this command

Behaviour:
- Reset: state=CLEAR; all counters 0, more_q=0, err_o=0; every output low except clear_acc_o=1 and busy_o=1. CLEAR lasts one cycle, then IDLE.
- States and encodings: IDLE=0, CLEAR=1, FETCH_W=2, PROG=3, FETCH_B=4, FETCH_IN=5, COMPUTE=6, STORE=7.
- IDLE + start_i:
  - Latch op and all config inputs into shadow registers; clear ft_cnt, more_q and err_o.
  - Range check: in_bits 0 or >IN_BITS; bl_base+BL_GROUP>SEG_COL; wl_idx>=SEG_ROW.
  - Check fails: err_o=1, done_o pulses next cycle, stay IDLE.
  - Check passes: go to CLEAR, FETCH_W, FETCH_B or FETCH_IN according to op.
- CLEAR: clear_acc_o=1 for one cycle -> IDLE with done_o pulse.
- FETCH_x:
  - src_req_o=1 until src_valid_i.
  - On src_valid_i: more_q<=src_more_i.
  - FETCH_W -> PROG; FETCH_B -> IDLE (done); FETCH_IN -> COMPUTE.
- PROG:
  - Lasts exactly BL_GROUP cycles; bl_cnt and bit_cnt step together 0..BL_GROUP-1.
  - Write column = wcol_base+ft_cnt, driven one-hot to every filter; write_col_sels_o is 0 outside PROG.
  - Leaving PROG: ft_cnt++. If more_q -> FETCH_W, else IDLE with done.
  - If wcol_base+ft_cnt>=N_WCOL on PROG entry: err_o=1, abort to IDLE with done, no write.
- COMPUTE:
  - Lasts in_bits*BL_GROUP cycles; trigger_acc_o=1 every COMPUTE cycle.
  - bl_cnt steps 0..BL_GROUP-1 and wraps; bit_cnt increments on each bl_cnt wrap.
  - Exit after the step bit=in_bits-1, bl=BL_GROUP-1 -> STORE.
- STORE:
  - snk_valid_o=1 until snk_ready_i.
  - On acceptance: more_q -> FETCH_IN; else IDLE with done.
- Combinational outputs:
  - wl_o = 1<<wl_idx.
  - bl_o = 1<<(bl_base+bl_cnt) in PROG/COMPUTE, else 0.
  - in_bit_o[f][p] = in_bit_buff_i[f][p][bit_cnt].
- Counters reset to 0 on entering any state other than PROG/COMPUTE.
- start_i outside IDLE is ignored.
- done_o is registered: it asserts the cycle after the final transition.
- Async reset mid-operation returns to CLEAR immediately; no done_o is generated.

Test Plan:
- Reset release -> one CLEAR cycle with clear_acc_o=1, then state_o=0, busy_o=0, all selects 0.
- LD_WEIGHTS, wcol_base=2, bl_base=4, two chunks (src_more_i=1 then 0):
  - Each PROG lasts 4 cycles with bl_o 0x10,0x20,0x40,0x80.
  - write_col_sels_o = 0x0004, then 0x0008.
  - ft_cnt_o ends at 2; one done_o.
- COMPUTE, in_bits=3, BL_GROUP=4:
  - trigger_acc_o high exactly 12 cycles; bit_cnt sequence 0,0,0,0,1,...,2.
  - snk_valid_o held 5 cycles until snk_ready_i, then done_o.
- Config errors:
  - in_bits=0 -> err_o=1, state stays IDLE, done_o pulse, no src_req_o.
  - wcol_base=15 with a second chunk -> err_o set at second PROG entry.
- LD_BIAS with src_valid_i delayed 7 cycles -> src_req_o high 7+1 cycles -> IDLE, done.
- Reset asserted mid-COMPUTE -> next edge state=CLEAR, trigger_acc_o=0, no done_o.
